vga_output_stage: RTL

Final pixel-output stage of the VGA path, placed between the pixel drawer and the board's DAC/sync pins. It aligns sync, enable and column timing to the drawer's pipeline latency and blanks outside the active area. It also applies a frame-stepped global brightness fade (fade in, fade out, reversal mid-fade), an optional colour-bar test pattern and a heartbeat/status LED bank. Colour depth, drawer latency, fade speed and heartbeat period are all parametrised.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_output_stage_if.sv | 22 ++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_output_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA output stage.
package vga_pkg;

   typedef enum logic [1:0] {
      BRIGHT     = 2'd0,
      FADING_OUT = 2'd1,
      DARK       = 2'd2,
      FADING_IN  = 2'd3
   } fade_state_t;

   localparam int unsigned DEFAULT_COLOR_BITS = 4;
   localparam int unsigned BAR_SHIFT          = 6;
   localparam int unsigned LED_COUNT          = 10;
   localparam int unsigned COLUMN_BITS        = 10;

endpackage

// File: rtl/vga_output_stage_if.sv
// Drawer/timing-generator pixel bus feeding the output stage.
interface vga_output_stage_if
   import vga_pkg::*;
#(
   parameter int unsigned COLOR_BITS = DEFAULT_COLOR_BITS
);
   logic [COLOR_BITS-1:0]  red_in;
   logic [COLOR_BITS-1:0]  green_in;
   logic [COLOR_BITS-1:0]  blue_in;
   logic                   hsync_in;
   logic                   vsync_in;
   logic                   display_enable;
   logic [COLUMN_BITS-1:0] column;

   modport master (
      output red_in, green_in, blue_in, hsync_in, vsync_in, display_enable, column
   );

   modport slave (
      input red_in, green_in, blue_in, hsync_in, vsync_in, display_enable, column
   );
endinterface

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register; zero depth degenerates to a wire.
module vga_delay_line #(
   parameter int unsigned           WIDTH       = 1,
   parameter int unsigned           DEPTH       = 1,
   parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
   input  logic             vga_clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = vga_clock ^ reset;
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stages [DEPTH];

         // Shift samples one stage per pixel clock
         always_ff @(posedge vga_clock) begin
            if (reset) begin
               for (int i = 0; i < int'(DEPTH); i++) stages[i] <= RESET_VALUE;
            end else begin
               stages[0] <= din;
               for (int i = 1; i < int'(DEPTH); i++) stages[i] <= stages[i-1];
            end
         end

         assign dout = stages[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_output_stage.sv
// Final VGA pixel stage: timing alignment, blanking, brightness fade,
// colour-bar test pattern and status LEDs.
module vga_output_stage
   import vga_pkg::*;
#(
   parameter int unsigned COLOR_BITS      = DEFAULT_COLOR_BITS,
   parameter int unsigned DRAW_LATENCY    = 1,
   parameter int unsigned FRAMES_PER_STEP = 2,
   parameter int unsigned HEARTBEAT_DIV   = 2_500_000,
   parameter int unsigned RESET_DARK      = 0
) (
   input  logic                  vga_clock,
   input  logic                  reset,
   vga_output_stage_if.slave     pix,
   input  logic                  fade_in_req,
   input  logic                  fade_out_req,
   input  logic                  test_pattern,
   output logic [COLOR_BITS-1:0] vga_red,
   output logic [COLOR_BITS-1:0] vga_green,
   output logic [COLOR_BITS-1:0] vga_blue,
   output logic                  vga_hsync,
   output logic                  vga_vsync,
   output logic                  fade_busy,
   output logic [LED_COUNT-1:0]  leds
);

   localparam int unsigned N        = COLOR_BITS;
   localparam int unsigned PROD_W   = 2 * N + 1;
   localparam int unsigned DL_WIDTH = 3 + COLUMN_BITS;
   localparam int unsigned STEP_W   = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam int unsigned HB_W     = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;

   localparam logic [N-1:0]        LEVEL_MAX = '1;
   localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
   localparam logic [HB_W-1:0]     HB_LAST   = HB_W'(HEARTBEAT_DIV - 1);
   localparam logic [DL_WIDTH-1:0] DL_RESET  = {2'b11, 1'b0, COLUMN_BITS'(0)};

   localparam logic [1:0] S_BRIGHT     = BRIGHT;
   localparam logic [1:0] S_FADING_OUT = FADING_OUT;
   localparam logic [1:0] S_DARK       = DARK;
   localparam logic [1:0] S_FADING_IN  = FADING_IN;

   logic [DL_WIDTH-1:0]    dl_out;
   logic                   d_hs, d_vs, d_de;
   logic [COLUMN_BITS-1:0] d_col;

   logic                   vs_prev, frame_tick;
   logic [1:0]             state, state_nx;
   logic [N-1:0]           level, level_nx;
   logic [STEP_W-1:0]      step_cnt, step_cnt_nx;
   logic [HB_W-1:0]        hb_cnt;
   logic                   heartbeat, test_pattern_q;

   logic [2:0]             bar;
   logic [N-1:0]           sel_red, sel_green, sel_blue;
   logic [N:0]             level_p1;
   logic [PROD_W-1:0]      prod_red, prod_green, prod_blue;
   logic                   unused_bits;

   // Align syncs, enable and column with the drawer's colour latency
   vga_delay_line #(
      .WIDTH       (DL_WIDTH),
      .DEPTH       (DRAW_LATENCY),
      .RESET_VALUE (DL_RESET)
   ) u_delay (
      .vga_clock (vga_clock),
      .reset     (reset),
      .din       ({pix.hsync_in, pix.vsync_in, pix.display_enable, pix.column}),
      .dout      (dl_out)
   );

   assign {d_hs, d_vs, d_de, d_col} = dl_out;

   // Frame tick on the falling edge of the aligned vsync
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         vs_prev    <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         vs_prev    <= d_vs;
         frame_tick <= vs_prev & ~d_vs;
      end
   end

   // Fade FSM next-state, level and step counter; accepted requests beat steps
   always_comb begin
      logic out_ok, in_ok, wrap;
      state_nx    = state;
      level_nx    = level;
      step_cnt_nx = step_cnt;
      out_ok      = fade_out_req & ~fade_in_req;
      in_ok       = fade_in_req & ~fade_out_req;
      wrap        = frame_tick && (step_cnt == STEP_LAST);
      case (state)
         S_BRIGHT: begin
            if (out_ok) begin
               state_nx    = S_FADING_OUT;
               step_cnt_nx = '0;
            end
         end
         S_DARK: begin
            if (in_ok) begin
               state_nx    = S_FADING_IN;
               step_cnt_nx = '0;
            end
         end
         S_FADING_OUT: begin
            if (in_ok) begin
               state_nx = S_FADING_IN;
            end else if (frame_tick) begin
               step_cnt_nx = wrap ? '0 : step_cnt + STEP_W'(1);
               if (wrap) begin
                  if (level <= N'(1)) begin
                     level_nx = '0;
                     state_nx = S_DARK;
                  end else begin
                     level_nx = level - N'(1);
                  end
               end
            end
         end
         default: begin
            if (out_ok) begin
               state_nx = S_FADING_OUT;
            end else if (frame_tick) begin
               step_cnt_nx = wrap ? '0 : step_cnt + STEP_W'(1);
               if (wrap) begin
                  if (level >= LEVEL_MAX - N'(1)) begin
                     level_nx = LEVEL_MAX;
                     state_nx = S_BRIGHT;
                  end else begin
                     level_nx = level + N'(1);
                  end
               end
            end
         end
      endcase
   end

   // Fade state register
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state     <= (RESET_DARK != 0) ? S_DARK : S_BRIGHT;
         level     <= (RESET_DARK != 0) ? '0 : LEVEL_MAX;
         step_cnt  <= '0;
         fade_busy <= 1'b0;
      end else begin
         state     <= state_nx;
         level     <= level_nx;
         step_cnt  <= step_cnt_nx;
         fade_busy <= (state_nx == S_FADING_OUT) || (state_nx == S_FADING_IN);
      end
   end

   // Colour source: drawer colour or colour bars from the aligned column
   always_comb begin
      bar       = d_col[BAR_SHIFT +: 3];
      sel_red   = pix.red_in;
      sel_green = pix.green_in;
      sel_blue  = pix.blue_in;
      if (test_pattern) begin
         sel_red   = {N{bar[0]}};
         sel_green = {N{bar[1]}};
         sel_blue  = {N{bar[2]}};
      end
   end

   // Brightness scaling: c * (level + 1) >> N
   assign level_p1   = {1'b0, level} + (N+1)'(1);
   assign prod_red   = PROD_W'(sel_red)   * PROD_W'(level_p1);
   assign prod_green = PROD_W'(sel_green) * PROD_W'(level_p1);
   assign prod_blue  = PROD_W'(sel_blue)  * PROD_W'(level_p1);

   assign unused_bits = ^{d_col[COLUMN_BITS-1:BAR_SHIFT+3], d_col[BAR_SHIFT-1:0],
                          prod_red[PROD_W-1], prod_red[N-1:0],
                          prod_green[PROD_W-1], prod_green[N-1:0],
                          prod_blue[PROD_W-1], prod_blue[N-1:0]};

   // Output register: blanked, scaled pixel plus aligned syncs
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         vga_red   <= '0;
         vga_green <= '0;
         vga_blue  <= '0;
         vga_hsync <= 1'b1;
         vga_vsync <= 1'b1;
      end else begin
         vga_red   <= d_de ? prod_red[2*N-1:N]   : '0;
         vga_green <= d_de ? prod_green[2*N-1:N] : '0;
         vga_blue  <= d_de ? prod_blue[2*N-1:N]  : '0;
         vga_hsync <= d_hs;
         vga_vsync <= d_vs;
      end
   end

   // Heartbeat divider and registered test-pattern status
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         hb_cnt         <= '0;
         heartbeat      <= 1'b0;
         test_pattern_q <= 1'b0;
      end else begin
         test_pattern_q <= test_pattern;
         if (hb_cnt == HB_LAST) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
         end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
         end
      end
   end

   assign leds = {(LED_COUNT-4)'(0), test_pattern_q, fade_busy, 1'b1, heartbeat};

endmodule
